burst_deinterleaver_pp: RTL and testbench
=========================================

Name: burst_deinterleaver_pp

Overview:
- Parametrised ping-pong block deinterleaver that sits between the demodulator bit-slicer and the Viterbi decoder. It generalises the fixed single-burst deinterleaver stage.
- Input beats of IN_W hard bits are written row-major into one bank. Completed bursts are read column-major as OUT_W-bit symbol beats.
- Two banks let burst N+1 fill while burst N drains, so no DUT reset is needed between bursts.

Parameters:
- ROWS, 8, interleaver rows.
- COLS, 16, interleaver columns; burst length NB = ROWS*COLS bits.
- IN_W, 4, bits per input beat; NB mod IN_W must be 0.
- OUT_W, 2, bits per output beat (code symbol width); NB mod OUT_W must be 0.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state on the next clk edge.
- in_data  in  IN_W  input bits; in_data[IN_W-1] is the earliest bit in time.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block can accept a beat; a beat transfers when in_valid && in_ready.
- in_abort  in  1  discard the partially filled burst in the write bank.
- out_data  out  OUT_W  deinterleaved symbol; out_data[OUT_W-1] is the earliest bit.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts; a beat transfers when out_valid && out_ready.
- out_last  out  1  marks the final beat of a burst.
- burst_done  out  1  one-cycle pulse on the cycle the last beat of a burst transfers.

Behaviour:
- Reset values:
  - in_ready=1, out_valid=0, out_data=0, out_last=0, burst_done=0.
  - Both banks EMPTY; write bank and read bank pointers both 0; all counters 0.
- Per-bank state machine: EMPTY -> FILLING (first accepted beat) -> FULL (NB/IN_W-th beat accepted) -> DRAINING (read side takes the bank) -> EMPTY (last output beat transfers).
- Write side:
  - Accepted beat number w (0-based) stores bit i of the beat (i=0 is in_data[IN_W-1]) at linear index k=w*IN_W+i.
  - Storage position: row r=k/COLS, column c=k%COLS.
  - On the final beat the bank becomes FULL and the write pointer toggles.
  - in_ready=1 whenever the current write bank is EMPTY or FILLING. It is combinational from bank state, so it never waits on out_ready.
- Read side:
  - Output beat j carries read indices m=j*OUT_W+b, where b=0 maps to out_data[OUT_W-1].
  - Index m reads column c=m/ROWS, row r=m%ROWS.
  - out_data, out_valid and out_last are registered.
  - out_valid rises on the cycle after the bank goes FULL (latency 1 clk from the last input beat), provided the read side is idle.
  - out_data holds stable while out_valid && !out_ready.
  - out_last=1 on beat NB/OUT_W-1.
  - On out_last transfer: bank becomes EMPTY, the read pointer toggles, and burst_done pulses.
  - If the other bank is already FULL, its first beat is presented on the next cycle (one bubble cycle between bursts).
- Both banks FULL or DRAINING: in_ready=0, and input beats presented during that time are not accepted.
- Same-cycle events:
  - A write completing bank A and a drain completing bank B on the same cycle are both honoured.
  - A bank freed by the drain accepts input on the following cycle.
- in_abort:
  - Resets the write-bank fill count and returns a FILLING bank to EMPTY.
  - A beat presented on the same cycle as in_abort is dropped.
  - in_abort has no effect on FULL or DRAINING banks.
- Reset mid-burst discards both banks. out_valid=0 from the cycle after the reset edge.
- Storage uses flops or distributed RAM, 2*NB bits; no bit reuse before a bank returns to EMPTY.

Optional Feature:
- Macro: DEINT_STATUS_EN.
- When defined:
  - Adds outputs burst_count[15:0], which increments on every burst_done and wraps 65535->0.
  - Adds drop_count[15:0], which increments on each cycle with in_valid && !in_ready, or with in_abort while a bank is FILLING. It saturates at 65535.
  - Both counters clear on reset.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package deint_pkg holds:
  - the bank-state enum (EMPTY, FILLING, FULL, DRAINING);
  - localparam functions for NB, NB/IN_W and NB/OUT_W;
  - a clog2 helper for counter widths.
- Sub-module deint_bank: one bank with a write port (IN_W bits at a row-major index) and a read port (OUT_W bits at a column-major index).
  - The top instantiates two banks plus the pointer and handshake control.

Test Plan:
1. Default parameters, out_ready=1. Feed 32 beats whose bits encode linear index k (pattern bit k=k%3==0). Expected response:
   - out_valid rises 1 clk after the 32nd beat.
   - 64 beats are output, matching the column-major permutation; out_last is on beat 63 and burst_done pulses once.
2. Back-to-back bursts with no idle cycles. Expected response:
   - in_ready stays 1 throughout.
   - Second burst output starts exactly 1 bubble after the first burst's out_last.
3. out_ready held 0 after the first burst. Expected response:
   - Second burst fills bank 1, then in_ready=0 after 64 accepted beats total.
   - out_data stays frozen until out_ready returns to 1.
4. in_abort asserted after 10 beats, then a full burst is sent. Expected response:
   - Output equals the permutation of the new burst only.
   - With DEINT_STATUS_EN defined, drop_count=1.
5. reset pulsed during draining beat 20. Expected response:
   - out_valid=0 on the next cycle and in_ready=1.
   - A fresh burst then decodes correctly.
6. ROWS=4, COLS=6, IN_W=3, OUT_W=2. Expected response:
   - 8 input beats give 12 output beats in the correct order.
   - With DEINT_STATUS_EN defined, burst_count=1.

Source files
------------

// File: rtl/deint_pkg.sv
// Shared types and sizing helpers for the ping-pong burst deinterleaver.
//   bank_state_e : per-bank lifecycle (EMPTY -> FILLING -> FULL -> DRAINING)
//   burst_bits   : NB = ROWS*COLS
//   in_beats     : NB/IN_W input beats per burst
//   out_beats    : NB/OUT_W output beats per burst
//   cnt_w        : bits needed to count 0..n-1 (minimum 1)
package deint_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    function automatic int unsigned burst_bits(input int unsigned rows, input int unsigned cols);
        return rows * cols;
    endfunction

    function automatic int unsigned in_beats(input int unsigned rows, input int unsigned cols,
                                             input int unsigned in_w);
        return (rows * cols) / in_w;
    endfunction

    function automatic int unsigned out_beats(input int unsigned rows, input int unsigned cols,
                                              input int unsigned out_w);
        return (rows * cols) / out_w;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/deint_bank.sv
// One interleaver bank of ROWS*COLS bits.
//   clk     : rising-edge clock
//   wr_en   : store wr_data as input beat number wr_beat (row-major fill)
//   wr_beat : input beat index within the burst
//   wr_data : IN_W bits, MSB is the earliest bit
//   rd_beat : output beat index within the burst (column-major read)
//   rd_data : OUT_W bits, MSB is the earliest bit (combinational)
module deint_bank
    import deint_pkg::*;
#(
    parameter int unsigned ROWS  = 8,
    parameter int unsigned COLS  = 16,
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 2,
    localparam int unsigned NB   = burst_bits(ROWS, COLS),
    localparam int unsigned WCW  = cnt_w(in_beats(ROWS, COLS, IN_W)),
    localparam int unsigned RCW  = cnt_w(out_beats(ROWS, COLS, OUT_W))
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [WCW-1:0]   wr_beat,
    input  logic [IN_W-1:0]  wr_data,
    input  logic [RCW-1:0]   rd_beat,
    output logic [OUT_W-1:0] rd_data
);

    localparam int unsigned AW  = cnt_w(NB);
    localparam int unsigned IDW = cnt_w(IN_W);
    localparam int unsigned ODW = cnt_w(OUT_W);

    // Bit k of mem holds linear index k = row*COLS + col.
    logic [NB-1:0] mem;

    // Row-major write: bit i of beat w lands at k = w*IN_W + i.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned a = 0; a < NB; a++) begin
                if (32'(wr_beat) == a / IN_W) begin
                    mem[AW'(a)] <= wr_data[IDW'(IN_W - 1 - (a % IN_W))];
                end
            end
        end
    end

    // Column-major read: index m maps to col m/ROWS, row m%ROWS.
    always_comb begin
        int unsigned m;
        rd_data = '0;
        m       = 0;
        for (int unsigned b = 0; b < OUT_W; b++) begin
            m = 32'(rd_beat) * OUT_W + b;
            rd_data[ODW'(OUT_W - 1 - b)] = mem[AW'((m % ROWS) * COLS + m / ROWS)];
        end
    end

endmodule

// File: rtl/burst_deinterleaver_pp.sv
// Ping-pong block deinterleaver: bursts are written row-major into one bank
// while the other bank drains column-major.
//   clk, reset          : clock, synchronous active-high reset
//   in_data/in_valid    : input beat, IN_W bits, MSB earliest
//   in_ready            : write bank can accept (combinational from bank state)
//   in_abort            : discard the partially filled write bank
//   out_data/out_valid  : registered output symbol, OUT_W bits, MSB earliest
//   out_ready           : downstream accept
//   out_last            : final beat of a burst
//   burst_done          : one-cycle pulse after the final beat transfers
// Optional status (macro DEINT_STATUS_EN): burst_count, drop_count.
module burst_deinterleaver_pp
    import deint_pkg::*;
#(
    parameter int unsigned ROWS  = 8,
    parameter int unsigned COLS  = 16,
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_abort,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             burst_done
`ifdef DEINT_STATUS_EN
    ,
    output logic [15:0]      burst_count,
    output logic [15:0]      drop_count
`endif
);

    localparam int unsigned IN_BEATS  = in_beats(ROWS, COLS, IN_W);
    localparam int unsigned OUT_BEATS = out_beats(ROWS, COLS, OUT_W);
    localparam int unsigned WCW       = cnt_w(IN_BEATS);
    localparam int unsigned RCW       = cnt_w(OUT_BEATS);

    bank_state_e      bank_state [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [WCW-1:0]   wr_cnt;
    logic [RCW-1:0]   rd_cnt;
    logic [OUT_W-1:0] bank_rd [2];

    logic             wr_open_c;
    logic             wr_fire_c;
    logic             wr_last_c;
    logic             rd_fire_c;
    logic [RCW-1:0]   rd_nxt_c;
    logic [RCW-1:0]   rd_idx_c;
    logic [OUT_W-1:0] rd_sel_c;

    // Handshake and bank read-address selection.
    always_comb begin
        wr_open_c = (bank_state[wr_ptr] == BANK_EMPTY) || (bank_state[wr_ptr] == BANK_FILLING);
        in_ready  = wr_open_c;
        wr_fire_c = in_valid && wr_open_c && !in_abort;
        wr_last_c = (wr_cnt == WCW'(IN_BEATS - 1));
        rd_fire_c = out_valid && out_ready;
        rd_nxt_c  = rd_cnt + RCW'(1);
        // Idle read side prefetches beat 0; otherwise look one beat ahead.
        rd_idx_c  = out_valid ? rd_nxt_c : '0;
        rd_sel_c  = bank_rd[rd_ptr];
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        deint_bank #(
            .ROWS  (ROWS),
            .COLS  (COLS),
            .IN_W  (IN_W),
            .OUT_W (OUT_W)
        ) u_bank (
            .clk     (clk),
            .wr_en   (wr_fire_c && (wr_ptr == 1'(g))),
            .wr_beat (wr_cnt),
            .wr_data (in_data),
            .rd_beat (rd_idx_c),
            .rd_data (bank_rd[g])
        );
    end

    // Bank state machines, pointers and registered output stage. The write
    // and read updates always touch different banks, so both may fire at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_state[0] <= BANK_EMPTY;
            bank_state[1] <= BANK_EMPTY;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            burst_done    <= 1'b0;
        end else begin
            burst_done <= 1'b0;

            if (in_abort) begin
                if (wr_open_c) begin
                    wr_cnt             <= '0;
                    bank_state[wr_ptr] <= BANK_EMPTY;
                end
            end else if (wr_fire_c) begin
                if (wr_last_c) begin
                    wr_cnt             <= '0;
                    bank_state[wr_ptr] <= BANK_FULL;
                    wr_ptr             <= ~wr_ptr;
                end else begin
                    wr_cnt             <= wr_cnt + WCW'(1);
                    bank_state[wr_ptr] <= BANK_FILLING;
                end
            end

            if (out_valid) begin
                if (rd_fire_c) begin
                    if (out_last) begin
                        bank_state[rd_ptr] <= BANK_EMPTY;
                        rd_ptr             <= ~rd_ptr;
                        rd_cnt             <= '0;
                        out_valid          <= 1'b0;
                        out_last           <= 1'b0;
                        burst_done         <= 1'b1;
                    end else begin
                        rd_cnt   <= rd_nxt_c;
                        out_data <= rd_sel_c;
                        out_last <= (rd_nxt_c == RCW'(OUT_BEATS - 1));
                    end
                end
            end else if (bank_state[rd_ptr] == BANK_FULL) begin
                bank_state[rd_ptr] <= BANK_DRAINING;
                rd_cnt             <= '0;
                out_data           <= rd_sel_c;
                out_valid          <= 1'b1;
                out_last           <= (OUT_BEATS == 1);
            end
        end
    end

`ifdef DEINT_STATUS_EN
    // Burst counter wraps; drop counter saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_count <= '0;
            drop_count  <= '0;
        end else begin
            if (rd_fire_c && out_last) begin
                burst_count <= burst_count + 16'd1;
            end
            if (((in_valid && !wr_open_c) ||
                 (in_abort && (bank_state[wr_ptr] == BANK_FILLING))) &&
                (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_burst_deinterleaver_pp.sv
// Self-checking bench for burst_deinterleaver_pp: default-parameter instance
// (8x16, 4-bit in, 2-bit out) and a small 4x6, 3-bit in, 2-bit out instance.
module tb_burst_deinterleaver_pp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: default parameters
    logic       a_reset, a_in_valid, a_in_ready, a_in_abort;
    logic [3:0] a_in_data;
    logic [1:0] a_out_data;
    logic       a_out_valid, a_out_ready, a_out_last, a_burst_done;
    // Instance B: ROWS=4 COLS=6 IN_W=3 OUT_W=2
    logic       b_reset, b_in_valid, b_in_ready, b_in_abort;
    logic [2:0] b_in_data;
    logic [1:0] b_out_data;
    logic       b_out_valid, b_out_ready, b_out_last, b_burst_done;
`ifdef DEINT_STATUS_EN
    logic [15:0] a_burst_count, a_drop_count, b_burst_count, b_drop_count;
`endif

    burst_deinterleaver_pp u_dut_a (
        .clk        (clk),
        .reset      (a_reset),
        .in_data    (a_in_data),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_abort   (a_in_abort),
        .out_data   (a_out_data),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_last   (a_out_last),
        .burst_done (a_burst_done)
`ifdef DEINT_STATUS_EN
        ,
        .burst_count(a_burst_count),
        .drop_count (a_drop_count)
`endif
    );

    burst_deinterleaver_pp #(.ROWS(4), .COLS(6), .IN_W(3), .OUT_W(2)) u_dut_b (
        .clk        (clk),
        .reset      (b_reset),
        .in_data    (b_in_data),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_abort   (b_in_abort),
        .out_data   (b_out_data),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_last   (b_out_last),
        .burst_done (b_burst_done)
`ifdef DEINT_STATUS_EN
        ,
        .burst_count(b_burst_count),
        .drop_count (b_drop_count)
`endif
    );

    // Output monitors: record every transferring beat as {last, data}.
    logic [2:0] aq[$];
    int         aq_cyc[$];
    logic [2:0] bq[$];
    int         a_done = 0;
    int         b_done = 0;

    always @(negedge clk) begin
        if (!a_reset && a_out_valid && a_out_ready) begin
            aq.push_back({a_out_last, a_out_data});
            aq_cyc.push_back(cyc);
        end
        if (!a_reset && a_burst_done) a_done++;
        if (!b_reset && b_out_valid && b_out_ready) bq.push_back({b_out_last, b_out_data});
        if (!b_reset && b_burst_done) b_done++;
    end

    int n_vec = 0;
    int n_bad = 0;
    int a_stall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference permutation for instance A (8x16): beat j = {last, bits}.
    function automatic logic [2:0] a_exp(input logic [127:0] bits, input int j);
        logic [2:0] e;
        e = '0;
        for (int b = 0; b < 2; b++) begin
            int m;
            int k;
            m = j * 2 + b;
            k = (m % 8) * 16 + m / 8;
            e[1-b] = bits[k];
        end
        e[2] = (j == 63);
        return e;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic a_push(input logic [3:0] d);
        int t;
        t = 0;
        a_in_data  = d;
        a_in_valid = 1'b1;
        while (!a_in_ready && t < 300) begin
            a_stall++;
            @(posedge clk);
            #1;
            t++;
        end
        if (!a_in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL a_push timeout: in_ready=0, expected 1");
        end else begin
            @(posedge clk);
            #1;
        end
        a_in_valid = 1'b0;
    endtask

    task automatic a_send(input logic [127:0] bits, input int nbeats);
        for (int w = 0; w < nbeats; w++) begin
            logic [3:0] d;
            for (int i = 0; i < 4; i++) d[3-i] = bits[w*4+i];
            a_push(d);
        end
    endtask

    task automatic b_push(input logic [2:0] d);
        int t;
        t = 0;
        b_in_data  = d;
        b_in_valid = 1'b1;
        while (!b_in_ready && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!b_in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL b_push timeout: in_ready=0, expected 1");
        end else begin
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
    endtask

    task automatic a_wait(input int n);
        int t;
        t = 0;
        while (aq.size() < n && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    task automatic a_cmp(input string name, input logic [127:0] bits, input int base);
        for (int j = 0; j < 64; j++) begin
            logic [2:0] act;
            act = (base + j < aq.size()) ? aq[base+j] : 3'bxxx;
            check($sformatf("%s beat %0d", name, j), 32'(act), 32'(a_exp(bits, j)));
        end
    endtask

    typedef struct packed {
        logic [7:0] j;
        logic [1:0] data;
        logic       last;
    } vec_t;

    vec_t tv_a[7];
    vec_t tv_b[12];

    logic [127:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic [23:0]  qb;
    logic [2:0]   e3;
    int base, base2, d0, s0, t;
`ifdef DEINT_STATUS_EN
    int drop0;
`endif

    initial begin
        // Hand-computed first beats of test 1 (bit k = (k%3==0)).
        tv_a[0] = '{8'd0,  2'b10, 1'b0};
        tv_a[1] = '{8'd1,  2'b01, 1'b0};
        tv_a[2] = '{8'd2,  2'b00, 1'b0};
        tv_a[3] = '{8'd3,  2'b10, 1'b0};
        tv_a[4] = '{8'd4,  2'b00, 1'b0};
        tv_a[5] = '{8'd5,  2'b10, 1'b0};
        tv_a[6] = '{8'd63, 2'b10, 1'b1};
        // Hand-computed 4x6 burst (bit k = (k%5==0)).
        tv_b[0]  = '{8'd0,  2'b10, 1'b0};
        tv_b[1]  = '{8'd1,  2'b00, 1'b0};
        tv_b[2]  = '{8'd2,  2'b00, 1'b0};
        tv_b[3]  = '{8'd3,  2'b00, 1'b0};
        tv_b[4]  = '{8'd4,  2'b00, 1'b0};
        tv_b[5]  = '{8'd5,  2'b01, 1'b0};
        tv_b[6]  = '{8'd6,  2'b00, 1'b0};
        tv_b[7]  = '{8'd7,  2'b10, 1'b0};
        tv_b[8]  = '{8'd8,  2'b01, 1'b0};
        tv_b[9]  = '{8'd9,  2'b00, 1'b0};
        tv_b[10] = '{8'd10, 2'b10, 1'b0};
        tv_b[11] = '{8'd11, 2'b00, 1'b1};

        for (int k = 0; k < 128; k++) p1[k] = (k % 3 == 0);
        for (int k = 0; k < 24; k++)  qb[k] = (k % 5 == 0);
        p2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        p3 = 128'hDEAD_BEEF_0F0F_A5A5_1357_9BDF_C3C3_6996;
        p4 = 128'hFFFF_0000_AAAA_5555_1234_8765_F00D_CAFE;
        p5 = 128'h8001_4002_2004_1008_0810_0420_0240_0180;
        p6 = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
        p7 = 128'h3C5A_96E1_0BAD_F00D_7777_1111_E0E0_0707;
        p8 = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
        p9 = 128'h9E37_79B9_7F4A_7C15_F39C_C060_5CED_C834;

        a_reset = 1'b1; a_in_valid = 1'b0; a_in_abort = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_reset = 1'b1; b_in_valid = 1'b0; b_in_abort = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        idle(2);

        // Reset state
        check("rst in_ready",   a_in_ready, 1);
        check("rst out_valid",  a_out_valid, 0);
        check("rst out_data",   a_out_data, 0);
        check("rst out_last",   a_out_last, 0);
        check("rst burst_done", a_burst_done, 0);
        check("rst b in_ready", b_in_ready, 1);
        check("rst b out_valid", b_out_valid, 0);
`ifdef DEINT_STATUS_EN
        check("rst burst_count", a_burst_count, 0);
        check("rst drop_count",  a_drop_count, 0);
`endif
        a_reset = 1'b0;
        b_reset = 1'b0;
        idle(1);

        // Test 1: single burst, latency, permutation
        base = aq.size(); d0 = a_done;
        a_send(p1, 32);
        check("t1 out_valid same cycle as bank full", a_out_valid, 0);
        idle(1);
        check("t1 out_valid 1 clk later", a_out_valid, 1);
        a_wait(base + 64);
        idle(4);
        check("t1 beat count", aq.size() - base, 64);
        check("t1 burst_done pulses", a_done - d0, 1);
        for (int v = 0; v < 7; v++) begin
            logic [2:0] act;
            int j;
            j = int'(tv_a[v].j);
            act = (base + j < aq.size()) ? aq[base+j] : 3'bxxx;
            check($sformatf("t1 table beat %0d", j), 32'(act), 32'({tv_a[v].last, tv_a[v].data}));
        end
        a_cmp("t1", p1, base);

        // Test 2: back-to-back bursts
        base = aq.size(); d0 = a_done; s0 = a_stall;
        a_send(p2, 32);
        a_send(p3, 32);
        check("t2 in_ready stalls", a_stall - s0, 0);
        a_wait(base + 128);
        idle(4);
        check("t2 beat count", aq.size() - base, 128);
        check("t2 burst_done pulses", a_done - d0, 2);
        if (aq_cyc.size() >= base + 65) begin
            check("t2 burst gap cycles", aq_cyc[base+64] - aq_cyc[base+63], 2);
            check("t2 first burst contiguous", aq_cyc[base+63] - aq_cyc[base], 63);
        end else begin
            check("t2 gap beats present", aq_cyc.size(), base + 65);
        end
        a_cmp("t2a", p2, base);
        a_cmp("t2b", p3, base + 64);

        // Test 3: downstream stalled, both banks occupied
        base = aq.size(); d0 = a_done;
        a_out_ready = 1'b0;
        a_send(p4, 32);
        a_send(p5, 32);
        e3 = a_exp(p4, 0);
        check("t3 in_ready after 64 beats", a_in_ready, 0);
        check("t3 out_valid held", a_out_valid, 1);
        check("t3 out_data frozen a", a_out_data, e3[1:0]);
`ifdef DEINT_STATUS_EN
        drop0 = a_drop_count;
`endif
        a_in_data = 4'hF; a_in_valid = 1'b1;
        idle(3);
        a_in_valid = 1'b0;
        check("t3 in_ready still 0", a_in_ready, 0);
        check("t3 out_data frozen b", a_out_data, e3[1:0]);
        check("t3 no transfers while stalled", aq.size() - base, 0);
`ifdef DEINT_STATUS_EN
        check("t3 drop_count delta", a_drop_count - drop0, 3);
`endif
        a_out_ready = 1'b1;
        a_wait(base + 128);
        idle(4);
        check("t3 beat count", aq.size() - base, 128);
        check("t3 burst_done pulses", a_done - d0, 2);
        a_cmp("t3a", p4, base);
        a_cmp("t3b", p5, base + 64);

        // Test 4: abort after 10 beats, beat on abort cycle dropped
        base = aq.size();
`ifdef DEINT_STATUS_EN
        drop0 = a_drop_count;
`endif
        a_send(p6, 10);
        a_in_abort = 1'b1; a_in_valid = 1'b1; a_in_data = 4'hF;
        idle(1);
        a_in_abort = 1'b0; a_in_valid = 1'b0;
        check("t4 in_ready after abort", a_in_ready, 1);
        a_send(p7, 32);
        a_wait(base + 64);
        idle(4);
        check("t4 beat count", aq.size() - base, 64);
        a_cmp("t4", p7, base);
`ifdef DEINT_STATUS_EN
        check("t4 drop_count delta", a_drop_count - drop0, 1);
`endif

        // Test 5: reset while draining beat 20
        base = aq.size();
        a_send(p8, 32);
        a_wait(base + 20);
        a_reset = 1'b1;
        idle(1);
        a_reset = 1'b0;
        check("t5 out_valid after reset", a_out_valid, 0);
        check("t5 in_ready after reset", a_in_ready, 1);
        check("t5 out_last after reset", a_out_last, 0);
        check("t5 beats before reset", aq.size() - base, 20);
`ifdef DEINT_STATUS_EN
        check("t5 burst_count cleared", a_burst_count, 0);
`endif
        base2 = aq.size();
        a_send(p9, 32);
        a_wait(base2 + 64);
        idle(4);
        check("t5 beat count", aq.size() - base2, 64);
        a_cmp("t5", p9, base2);
`ifdef DEINT_STATUS_EN
        check("t5 burst_count", a_burst_count, 1);
        check("t5 drop_count", a_drop_count, 0);
`endif

        // Test 6: 4x6 instance, 3-bit in, 2-bit out
        for (int w = 0; w < 8; w++) begin
            logic [2:0] d;
            for (int i = 0; i < 3; i++) d[2-i] = qb[w*3+i];
            b_push(d);
        end
        check("t6 out_valid same cycle as bank full", b_out_valid, 0);
        t = 0;
        while (bq.size() < 12 && t < 200) begin
            idle(1);
            t++;
        end
        idle(4);
        check("t6 beat count", bq.size(), 12);
        check("t6 burst_done pulses", b_done, 1);
        for (int v = 0; v < 12; v++) begin
            logic [2:0] act;
            act = (v < bq.size()) ? bq[v] : 3'bxxx;
            check($sformatf("t6 beat %0d", v), 32'(act), 32'({tv_b[v].last, tv_b[v].data}));
        end
`ifdef DEINT_STATUS_EN
        check("t6 burst_count", b_burst_count, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
